bp_fe_queue_replay_fifo: RTL and testbench
==========================================

# bp_fe_queue_replay_fifo

Instruction-fetch queue between the front end and the BE scheduler. Holds FE queue packets (fetch or exception messages), presents the oldest unread packet to issue, and keeps issued-but-uncommitted packets so they can be replayed. The scheduler drives three controls: clear (`clr_i`), replay (`roll_i`) and commit (`deq_i`). Three pointers (write, read, commit) and a register-array store implement the block.

## Interface
- `els_p`, default 8: entry count; must be a power of 2 and at least 2.
- `data_width_p`, default 128: FE queue packet width.
- `clk_i` input, 1 bit: clock.
- `reset_n_i` input, 1 bit: synchronous, active-low reset.
- `data_i` input, `data_width_p` bits: packet from the FE.
- `v_i` input, 1 bit: FE packet valid.
- `ready_o` output, 1 bit: space available. Ready/valid handshake; the FE may use the `v_i`/`ready_o` pair as a yumi.
- `data_o` output, `data_width_p` bits: oldest unread packet.
- `v_o` output, 1 bit: `data_o` valid.
- `yumi_i` input, 1 bit: scheduler consumes `data_o` this cycle. Legal only when `v_o` is 1.
- `clr_i` input, 1 bit: discard all unread entries.
- `roll_i` input, 1 bit: rewind the read pointer to the commit pointer.
- `deq_i` input, 1 bit: retire the oldest uncommitted entry.
- `empty_o` output, 1 bit: no unread and no uncommitted entries (write pointer equals commit pointer).

## Operation
- **Pointers.** `wptr`, `rptr` and `cptr` are each `$clog2(els_p)+1` bits wide. The MSB is a wrap bit; the low bits index the array. All pointer arithmetic is modulo 2·`els_p`.
- **Invariant.** `cptr` ≤ `rptr` ≤ `wptr` (in circular order), and `wptr` − `cptr` ≤ `els_p`.
- **Full.** Full when `wptr` − `cptr` == `els_p`, i.e. low bits equal and wrap bits differ. `ready_o` = ~full & `reset_n_i`.
- **Unread data.** `v_o` = (`rptr` != `wptr`) & `reset_n_i`. `data_o` = mem[`rptr` low bits], a combinational read of the registered array.
- **Enqueue.** `enq` = `v_i` & `ready_o` & ~`clr_i`. When set, mem[`wptr`] is written with `data_i`. A `v_i` during `clr_i` is dropped, but the handshake still completes if `ready_o` is 1.
- **Commit.** `deq_eff` = `deq_i` & (`cptr` != `rptr`). Commit never passes read; an illegal `deq_i` is ignored. Next commit pointer: `cptr_n` = `cptr` + `deq_eff`.
- **Read.** `yumi_eff` = `yumi_i` & `v_o` & ~`roll_i`.
  - `rptr_n` = `roll_i` ? `cptr_n` : `rptr` + `yumi_eff`.
  - Replay includes the entry committed in the same cycle, so it rewinds to the post-commit pointer.
- **Write.** `wptr_n` = `clr_i` ? `rptr_n` : `wptr` + `enq`.
- **Clear and replay together.** `rptr` = `wptr` = `cptr_n`. Every uncommitted and unread entry is discarded.
- **Simultaneous yumi, deq and enq** with no `clr_i`/`roll_i`: all three pointers advance independently in the same cycle.
- **Full and deq in the same cycle.** `ready_o` stays 0 that cycle; the freed space is visible the next cycle.
- **Reset.** `reset_n_i` = 0 sets all pointers to 0.
  - While reset is asserted: `ready_o` = 0, `v_o` = 0, `empty_o` = 1. `data_o` is unspecified and the array is not cleared.
  - Reset asserted mid-stream discards everything; no partial state survives.

## Timing
- Enqueue to `v_o`: 1 cycle (registered `wptr`), except under the bypass configuration.
- Pointer updates for consume, replay, clear and commit take effect on the next edge. All outputs are combinational from pointer registers only, except in bypass mode.
- A replayed entry is visible on `data_o` the cycle after `roll_i`.
- Maximum throughput is 1 enqueue plus 1 consume plus 1 commit per cycle.
- First cycle after reset deasserts: `ready_o` = 1, `v_o` = 0, `empty_o` = 1.

## Configuration
- **`BP_FE_QUEUE_BYPASS_EN` defined.** When `rptr` == `wptr` and `enq` is 1, `data_o` = `data_i` and `v_o` = 1 in the same cycle.
  - If `yumi_i` is asserted in that cycle, the entry is still written at `wptr`, so it remains replayable. Both `wptr` and `rptr` advance.
  - `roll_i` and `clr_i` suppress the bypass.
- **Macro undefined.** No combinational path from `v_i`/`data_i` to `v_o`/`data_o`; enqueue-to-valid is 1 cycle.

## Test plan
- **Fill and drain.** `els_p` = 8. Enqueue packets 0x1–0x8 with no yumi → `ready_o` = 0 after the 8th. Yumi 8 times → `data_o` sequence 0x1–0x8. 8× `deq_i` → `empty_o` = 1; `ready_o` = 1 the cycle after the first deq.
- **Replay.** Enqueue A, B, C. Yumi A, B. Deq A. Assert `roll_i` → the next `data_o` is B, then C.
- **Clear.** Enqueue A–D, yumi A, pulse `clr_i` while `v_i` = 1 with E → `v_o` = 0 next cycle and E is not stored. Deq A → `empty_o` = 1.
- **Simultaneous events.** `clr_i`, `roll_i` and `deq_i` in one cycle with 3 uncommitted entries → all pointers equal `cptr` + 1 and `empty_o` = 1. Wrap check: 20 enqueue/yumi/deq cycles with `els_p` = 8 → data order preserved across the wrap.
- **Illegal inputs and reset.** Assert `deq_i` with `cptr` == `rptr`, and `yumi_i` with `v_o` = 0 → no pointer change. Assert `reset_n_i` = 0 with 5 entries held → the next cycle shows `ready_o` = 0 and `v_o` = 0; after release, `empty_o` = 1.
- **Bypass (with `BP_FE_QUEUE_BYPASS_EN`).** On an empty queue, `v_i` = 1 with 0xAB → `v_o` = 1 and `data_o` = 0xAB in the same cycle. Yumi that cycle, then `roll_i` → 0xAB is re-presented.

Source files
------------

// File: rtl/bp_fe_queue_replay_fifo.sv
// rtl/bp_fe_queue_replay_fifo.sv - FE queue with read/commit pointers for replay
// Optional same-cycle bypass of empty-queue enqueues: BP_FE_QUEUE_BYPASS_EN
module bp_fe_queue_replay_fifo #(
  parameter int els_p        = 8,
  parameter int data_width_p = 128
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [data_width_p-1:0] data_i,
  input  logic                    v_i,
  output logic                    ready_o,
  output logic [data_width_p-1:0] data_o,
  output logic                    v_o,
  input  logic                    yumi_i,
  input  logic                    clr_i,
  input  logic                    roll_i,
  input  logic                    deq_i,
  output logic                    empty_o
);

  localparam int idx_w = $clog2(els_p);
  localparam int ptr_w = idx_w + 1;

  logic [ptr_w-1:0] wptr_q, wptr_d;
  logic [ptr_w-1:0] rptr_q, rptr_d;
  logic [ptr_w-1:0] cptr_q, cptr_d;
  logic [data_width_p-1:0] mem_q [els_p];

  logic full, enq, unread, bypass, deq_eff, yumi_eff;

  always_comb begin
    // Same index with opposite wrap bits: write has lapped commit by els_p.
    full = (wptr_q[idx_w-1:0] == cptr_q[idx_w-1:0]) &&
           (wptr_q[ptr_w-1] != cptr_q[ptr_w-1]);
    ready_o = ~full & reset_n_i;
    enq     = v_i & ready_o & ~clr_i;
    unread  = (rptr_q != wptr_q);
    bypass  = 1'b0;
`ifdef BP_FE_QUEUE_BYPASS_EN
    bypass  = ~unread & enq & ~roll_i;
`endif
    v_o     = (unread | bypass) & reset_n_i;
    data_o  = bypass ? data_i : mem_q[rptr_q[idx_w-1:0]];
    empty_o = (wptr_q == cptr_q) | ~reset_n_i;

    deq_eff  = deq_i & (cptr_q != rptr_q);
    yumi_eff = yumi_i & v_o & ~roll_i;

    // Replay rewinds to the post-commit pointer; clear then collapses write onto read.
    cptr_d = cptr_q + ptr_w'(deq_eff);
    rptr_d = roll_i ? cptr_d : rptr_q + ptr_w'(yumi_eff);
    wptr_d = clr_i ? rptr_d : wptr_q + ptr_w'(enq);

    if (!reset_n_i) begin
      cptr_d = '0;
      rptr_d = '0;
      wptr_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    wptr_q <= wptr_d;
    rptr_q <= rptr_d;
    cptr_q <= cptr_d;
  end

  // Storage is intentionally not reset; pointers alone define validity.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wptr_q[idx_w-1:0]] <= data_i;
  end

endmodule

// File: tb/tb_bp_fe_queue_replay_fifo.sv
// tb/tb_bp_fe_queue_replay_fifo.sv - randomized and directed bench for bp_fe_queue_replay_fifo
module tb_bp_fe_queue_replay_fifo;

  localparam int N  = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n_i;
  logic [DW-1:0] data_i, data_o;
  logic          v_i, ready_o, v_o, yumi_i, clr_i, roll_i, deq_i, empty_o;

  always #5 clk = ~clk;

  bp_fe_queue_replay_fifo #(.els_p(N), .data_width_p(DW)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .data_i(data_i), .v_i(v_i), .ready_o(ready_o),
    .data_o(data_o), .v_o(v_o), .yumi_i(yumi_i), .clr_i(clr_i), .roll_i(roll_i),
    .deq_i(deq_i), .empty_o(empty_o)
  );

  int errors = 0;
  int checks = 0;

  // Model: q holds every uncommitted packet oldest first; the first nread have been issued.
  logic [DW-1:0] q[$];
  int            nread = 0;

  task automatic idle_inputs;
    v_i = 0; data_i = '0; yumi_i = 0; clr_i = 0; roll_i = 0; deq_i = 0;
  endtask

  task automatic drive_cycle(input logic v, input logic [DW-1:0] d, input logic y,
                             input logic clr, input logic roll, input logic deq);
    logic e_ready, e_v, e_empty, enq, byp, yeff, deqeff;
    logic [DW-1:0] e_data;
    @(negedge clk);
    v_i = v; data_i = d; yumi_i = y; clr_i = clr; roll_i = roll; deq_i = deq;
    #1;
    e_ready = (q.size() < N);
    e_empty = (q.size() == 0);
    enq     = v && e_ready && !clr;
    byp     = 1'b0;
`ifdef BP_FE_QUEUE_BYPASS_EN
    byp     = (nread == q.size()) && enq && !roll;
`endif
    e_v     = (nread < q.size()) || byp;
    e_data  = byp ? d : ((nread < q.size()) ? q[nread] : '0);
    checks++;
    if (ready_o !== e_ready) begin errors++; $display("FAIL ready_o: got %b expected %b", ready_o, e_ready); end
    checks++;
    if (v_o !== e_v) begin errors++; $display("FAIL v_o: got %b expected %b", v_o, e_v); end
    checks++;
    if (empty_o !== e_empty) begin errors++; $display("FAIL empty_o: got %b expected %b", empty_o, e_empty); end
    if (e_v) begin
      checks++;
      if (data_o !== e_data) begin errors++; $display("FAIL data_o: got %h expected %h", data_o, e_data); end
    end
    deqeff = deq && (nread > 0);
    yeff   = y && e_v && !roll;
    if (deqeff) begin void'(q.pop_front()); nread--; end
    if (roll) nread = 0;
    else if (yeff) nread++;
    if (clr) while (q.size() > nread) void'(q.pop_back());
    if (enq) q.push_back(d);
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic drain;
    for (int k = 0; k < 4 * N && q.size() > 0; k++)
      drive_cycle(0, '0, nread < q.size(), 0, 0, nread > 0);
    checks++;
    if (q.size() != 0 || empty_o !== 1'b1) begin errors++; $display("FAIL drain: empty_o %b, expected 1", empty_o); end
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset_n_i = 0; idle_inputs();
    repeat (2) begin
      @(negedge clk); #1;
      checks++;
      if ({ready_o, v_o, empty_o} !== 3'b001) begin errors++; $display("FAIL reset_hold: got rdy/v/empty %b expected 001", {ready_o, v_o, empty_o}); end
    end
    q.delete(); nread = 0;
    reset_n_i = 1;
    @(posedge clk); #1;
    checks++;
    if ({ready_o, v_o, empty_o} !== 3'b101) begin errors++; $display("FAIL reset_release: got rdy/v/empty %b expected 101", {ready_o, v_o, empty_o}); end
  endtask

  task automatic test_fill_drain;
    for (int i = 1; i <= N; i++) drive_cycle(1, DW'(i), 0, 0, 0, 0);
    checks++;
    if (ready_o !== 1'b0) begin errors++; $display("FAIL fill_full: ready_o %b expected 0", ready_o); end
    for (int i = 1; i <= N; i++) begin
      checks++;
      if (data_o !== DW'(i)) begin errors++; $display("FAIL drain_order: data_o %h expected %h", data_o, DW'(i)); end
      drive_cycle(0, '0, 1, 0, 0, 0);
    end
    drive_cycle(0, '0, 0, 0, 0, 1);
    checks++;
    if (ready_o !== 1'b1) begin errors++; $display("FAIL ready_after_deq: ready_o %b expected 1", ready_o); end
    repeat (N - 1) drive_cycle(0, '0, 0, 0, 0, 1);
    checks++;
    if (empty_o !== 1'b1) begin errors++; $display("FAIL fill_empty: empty_o %b expected 1", empty_o); end
  endtask

  task automatic test_replay;
    drive_cycle(1, 32'hA, 0, 0, 0, 0);
    drive_cycle(1, 32'hB, 0, 0, 0, 0);
    drive_cycle(1, 32'hC, 0, 0, 0, 0);
    drive_cycle(0, '0, 1, 0, 0, 0);
    drive_cycle(0, '0, 1, 0, 0, 0);
    drive_cycle(0, '0, 0, 0, 0, 1);
    drive_cycle(0, '0, 0, 0, 1, 0);
    checks++;
    if (v_o !== 1'b1 || data_o !== 32'hB) begin errors++; $display("FAIL replay_first: data_o %h expected 0000000b", data_o); end
    drive_cycle(0, '0, 1, 0, 0, 0);
    checks++;
    if (data_o !== 32'hC) begin errors++; $display("FAIL replay_second: data_o %h expected 0000000c", data_o); end
    drain();
  endtask

  task automatic test_clear;
    for (int i = 0; i < 4; i++) drive_cycle(1, 32'hD0 + DW'(i), 0, 0, 0, 0);
    drive_cycle(0, '0, 1, 0, 0, 0);
    drive_cycle(1, 32'hEE, 0, 1, 0, 0);
    checks++;
    if (v_o !== 1'b0) begin errors++; $display("FAIL clear_v: v_o %b expected 0", v_o); end
    drive_cycle(0, '0, 0, 0, 0, 1);
    checks++;
    if (empty_o !== 1'b1) begin errors++; $display("FAIL clear_empty: empty_o %b expected 1", empty_o); end
  endtask

  task automatic test_simultaneous;
    for (int i = 0; i < 3; i++) drive_cycle(1, 32'h30 + DW'(i), 0, 0, 0, 0);
    repeat (3) drive_cycle(0, '0, 1, 0, 0, 0);
    drive_cycle(0, '0, 0, 1, 1, 1);
    checks++;
    if (empty_o !== 1'b1 || v_o !== 1'b0) begin errors++; $display("FAIL clr_roll_deq: empty/v %b%b expected 10", empty_o, v_o); end
  endtask

  task automatic test_wrap;
    logic [DW-1:0] next_exp = 32'h100;
    for (int i = 0; i < 20; i++) begin
      if (v_o) begin
        checks++;
        if (data_o !== next_exp) begin errors++; $display("FAIL wrap_order: data_o %h expected %h", data_o, next_exp); end
        next_exp++;
      end
      drive_cycle(1, 32'h100 + DW'(i), v_o, 0, 0, 1);
    end
    drain();
  endtask

  task automatic test_illegal;
    drive_cycle(0, '0, 1, 0, 0, 1);
    checks++;
    if (empty_o !== 1'b1 || v_o !== 1'b0) begin errors++; $display("FAIL illegal_empty: empty/v %b%b expected 10", empty_o, v_o); end
    drive_cycle(1, 32'h55, 0, 0, 0, 0);
    drive_cycle(0, '0, 0, 0, 0, 1);
    checks++;
    if (v_o !== 1'b1 || data_o !== 32'h55) begin errors++; $display("FAIL illegal_deq: data_o %h expected 00000055", data_o); end
    drain();
  endtask

  task automatic test_reset_midstream;
    for (int i = 0; i < 5; i++) drive_cycle(1, 32'h70 + DW'(i), i < 2, 0, 0, 0);
    @(negedge clk);
    reset_n_i = 0;
    @(posedge clk); #1;
    checks++;
    if (ready_o !== 1'b0 || v_o !== 1'b0) begin errors++; $display("FAIL midreset: ready/v %b%b expected 00", ready_o, v_o); end
    q.delete(); nread = 0;
    @(negedge clk);
    reset_n_i = 1;
    @(posedge clk); #1;
    checks++;
    if (empty_o !== 1'b1 || v_o !== 1'b0) begin errors++; $display("FAIL midreset_release: empty/v %b%b expected 10", empty_o, v_o); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 1500; i++)
      drive_cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0);
    drain();
  endtask

`ifdef BP_FE_QUEUE_BYPASS_EN
  task automatic test_bypass;
    drive_cycle(1, 32'hAB, 1, 0, 0, 0);
    drive_cycle(0, '0, 0, 0, 1, 0);
    checks++;
    if (v_o !== 1'b1 || data_o !== 32'hAB) begin errors++; $display("FAIL bypass_replay: data_o %h expected 000000ab", data_o); end
    drain();
  endtask
`endif

  initial begin
    reset_n_i = 0;
    idle_inputs();
    test_reset();
    test_fill_drain();
    test_replay();
    test_clear();
    test_simultaneous();
    test_wrap();
    test_illegal();
`ifdef BP_FE_QUEUE_BYPASS_EN
    test_bypass();
`endif
    test_random();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
